// File: rtl/mx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mx_pkg                                                           |
// | Purpose : FP32 field layout, E8M0 special codes and lane classification    |
// |           helpers shared by the MX shared-scale generator.                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mx_pkg;

   localparam int FP32_W       = 32;
   localparam int FP32_EXP_W   = 8;
   localparam int FP32_EXP_LSB = 23;
   localparam int FP32_EXP_MSB = 30;
   localparam int FP32_MAN_MSB = 22;

   localparam logic [FP32_EXP_W-1:0] FP32_EXP_ALL1 = 8'hFF;
   localparam logic [7:0]            E8M0_NAN      = 8'hFF;
   localparam logic [7:0]            E8M0_INF_SAT  = 8'hFE;
   localparam logic [7:0]            E8M0_ZERO     = 8'h00;

   // Classification of one element, or of a group of merged elements.
   typedef struct packed {
      logic                  nan;
      logic                  inf;
      logic [FP32_EXP_W-1:0] exp_eff;
   } fp32_class_t;

   // Sign is irrelevant to the scale; specials contribute no exponent.
   // Subnormals and zero carry exponent field 0, so they contribute 0.
   function automatic fp32_class_t fp32_class(input logic [FP32_W-1:0] bits);
      fp32_class_t           c;
      logic [FP32_EXP_W-1:0] e;
      logic                  man_nz;
      e         = bits[FP32_EXP_MSB:FP32_EXP_LSB];
      man_nz    = |bits[FP32_MAN_MSB:0];
      c.nan     = 1'b0;
      c.inf     = 1'b0;
      c.exp_eff = '0;
      if (e == FP32_EXP_ALL1) begin
         c.nan = man_nz;
         c.inf = ~man_nz;
      end else begin
         c.exp_eff = e;
      end
      return c;
   endfunction

   // Merge two classifications: larger finite exponent, OR of the flags.
   function automatic fp32_class_t fp32_class_merge(input fp32_class_t a, input fp32_class_t b);
      fp32_class_t m;
      m.nan     = a.nan | b.nan;
      m.inf     = a.inf | b.inf;
      m.exp_eff = (a.exp_eff > b.exp_eff) ? a.exp_eff : b.exp_eff;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mx_lane_max.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mx_lane_max                                                      |
// | Purpose : Combinational compare tree over LANES FP32 elements giving the   |
// |           largest finite biased exponent and any-NaN / any-Inf flags.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mx_lane_max
   import mx_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic [LANES*FP32_W-1:0] in_data,
   output logic [FP32_EXP_W-1:0]   max_exp,
   output logic                    any_nan,
   output logic                    any_inf
);

   // Heap-ordered tree: leaves at LANES-1 .. 2*LANES-2, root at index 0.
   fp32_class_t node [2*LANES-1];

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_leaf
         assign node[LANES-1+gi] = fp32_class(in_data[FP32_W*gi +: FP32_W]);
      end
      for (gi = 0; gi < LANES-1; gi++) begin : g_node
         assign node[gi] = fp32_class_merge(node[2*gi+1], node[2*gi+2]);
      end
   endgenerate

   assign max_exp = node[0].exp_eff;
   assign any_nan = node[0].nan;
   assign any_inf = node[0].inf;

endmodule
`default_nettype wire

// File: rtl/mx_block_scale_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mx_block_scale_acc                                               |
// | Purpose : Streaming E8M0 shared-scale generator for FP32 -> MX blocks.     |
// |           Accumulates the block max exponent and NaN/Inf flags over        |
// |           BLOCK_SIZE/LANES beats and emits one scale per block.            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mx_block_scale_acc
   import mx_pkg::*;
#(
   parameter int LANES        = 4,
   parameter int BLOCK_SIZE   = 32,
   parameter int SCALE_OFFSET = 3,
   parameter bit INF_AS_NAN   = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*FP32_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              out_scale,
   output logic                    out_nan,
   output logic                    out_inf
);

   localparam int               BEATS     = BLOCK_SIZE / LANES;
   localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [7:0]       OFFSET    = 8'(SCALE_OFFSET);

   logic [CNT_W-1:0]      beat_cnt;
   logic [FP32_EXP_W-1:0] acc_max;
   logic                  acc_nan;
   logic                  acc_inf;

   logic [FP32_EXP_W-1:0] beat_max;
   logic                  beat_nan;
   logic                  beat_inf;

   logic [FP32_EXP_W-1:0] merged_max;
   logic                  merged_nan;
   logic                  merged_inf;
   logic [7:0]            next_scale;

   logic accept;
   logic last_beat;
   logic final_accept;

   mx_lane_max #(
      .LANES (LANES)
   ) u_lane_max (
      .in_data (in_data),
      .max_exp (beat_max),
      .any_nan (beat_nan),
      .any_inf (beat_inf)
   );

   // A held scale only blocks input while downstream refuses it.
   assign in_ready     = ~out_valid | out_ready;
   assign accept       = in_valid & in_ready & ~flush;
   assign last_beat    = (beat_cnt == LAST_BEAT);
   assign final_accept = accept & last_beat;

   // Combine the running block state with the current beat and derive the scale.
   always_comb begin
      merged_max = (beat_max > acc_max) ? beat_max : acc_max;
      merged_nan = acc_nan | beat_nan;
      merged_inf = acc_inf | beat_inf;
      next_scale = E8M0_ZERO;
      if (merged_nan) begin
         next_scale = E8M0_NAN;
      end else if (merged_inf) begin
         next_scale = INF_AS_NAN ? E8M0_NAN : E8M0_INF_SAT;
      end else if (merged_max > OFFSET) begin
         next_scale = merged_max - OFFSET;
      end
   end

   // Beat counter and block accumulators; flush abandons the partial block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         acc_max  <= '0;
         acc_nan  <= 1'b0;
         acc_inf  <= 1'b0;
      end else if (flush) begin
         beat_cnt <= '0;
         acc_max  <= '0;
         acc_nan  <= 1'b0;
         acc_inf  <= 1'b0;
      end else if (accept) begin
         if (last_beat) begin
            beat_cnt <= '0;
            acc_max  <= '0;
            acc_nan  <= 1'b0;
            acc_inf  <= 1'b0;
         end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            acc_max  <= merged_max;
            acc_nan  <= merged_nan;
            acc_inf  <= merged_inf;
         end
      end
   end

   // One-deep output register; a finishing block may replace a scale being consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_scale <= '0;
         out_nan   <= 1'b0;
         out_inf   <= 1'b0;
      end else if (final_accept) begin
         out_valid <= 1'b1;
         out_scale <= next_scale;
         out_nan   <= merged_nan;
         out_inf   <= merged_inf & ~merged_nan;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mx_block_scale_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mx_block_scale_acc                                            |
// | Purpose : Directed self-checking bench for mx_block_scale_acc (default,    |
// |           INF_AS_NAN=1 and single-beat LANES=32 configurations).           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mx_block_scale_acc;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         flush     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic [127:0] in_data   = '0;
   logic         in_ready, out_valid, out_nan, out_inf;
   logic [7:0]   out_scale;

   logic         ian_in_ready, ian_out_valid, ian_out_nan, ian_out_inf;
   logic [7:0]   ian_out_scale;

   logic          in_valid32  = 1'b0;
   logic          out_ready32 = 1'b1;
   logic [1023:0] in_data32   = '0;
   logic          in_ready32, out_valid32, out_nan32, out_inf32;
   logic [7:0]    out_scale32;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mx_block_scale_acc dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_scale(out_scale),
      .out_nan(out_nan), .out_inf(out_inf)
   );

   mx_block_scale_acc #(.INF_AS_NAN(1'b1)) dut_ian (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ian_in_ready),
      .in_data(in_data), .out_valid(ian_out_valid), .out_ready(out_ready), .out_scale(ian_out_scale),
      .out_nan(ian_out_nan), .out_inf(ian_out_inf)
   );

   mx_block_scale_acc #(.LANES(32), .BLOCK_SIZE(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid32), .in_ready(in_ready32),
      .in_data(in_data32), .out_valid(out_valid32), .out_ready(out_ready32), .out_scale(out_scale32),
      .out_nan(out_nan32), .out_inf(out_inf32)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One beat, accepted on the next rising edge; returns at edge + 1.
   task automatic beat(input logic [127:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // Seven uniform beats followed by a check that no scale is out yet.
   task automatic send_seven(input logic [31:0] v, input string tag);
      for (int b = 0; b < 7; b++) beat({4{v}});
      check(tag, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [127:0] d;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_scale", {24'd0, out_scale}, 32'd0);
      check("rst_nan",   {31'd0, out_nan},   32'd0);
      check("rst_inf",   {31'd0, out_inf},   32'd0);
      check("rst_ready", {31'd0, in_ready},  32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: exp 127 everywhere -> 124, valid one clock after beat 8
      send_seven(32'h3F800000, "t1_pre_valid");
      beat({4{32'h3F800000}});
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_scale", {24'd0, out_scale}, 32'h7C);
      check("t1_nan",   {31'd0, out_nan},   32'd0);
      check("t1_inf",   {31'd0, out_inf},   32'd0);
      @(posedge clk);
      #1;
      check("t1_drain", {31'd0, out_valid}, 32'd0);

      // 2: single subnormal, rest zero -> saturate to 0
      beat({96'd0, 32'h00000001});
      for (int b = 0; b < 7; b++) beat(128'd0);
      check("t2_valid", {31'd0, out_valid}, 32'd1);
      check("t2_scale", {24'd0, out_scale}, 32'd0);
      check("t2_ian_scale", {24'd0, ian_out_scale}, 32'd0);

      // 3a: NaN on beat 3 lane 2, Inf on beat 5 lane 0 -> NaN wins
      for (int b = 0; b < 8; b++) begin
         d = {4{32'h3F800000}};
         if (b == 2) d[95:64] = 32'h7FC00000;
         if (b == 4) d[31:0]  = 32'h7F800000;
         beat(d);
      end
      check("t3a_scale", {24'd0, out_scale}, 32'hFF);
      check("t3a_nan",   {31'd0, out_nan},   32'd1);
      check("t3a_inf",   {31'd0, out_inf},   32'd0);
      check("t3a_ian_scale", {24'd0, ian_out_scale}, 32'hFF);

      // 3b: negative Inf only -> FE, or FF when Inf is treated as NaN
      for (int b = 0; b < 8; b++) begin
         d = {4{32'h3F800000}};
         if (b == 0) d[63:32] = 32'hFF800000;
         beat(d);
      end
      check("t3b_scale", {24'd0, out_scale}, 32'hFE);
      check("t3b_inf",   {31'd0, out_inf},   32'd1);
      check("t3b_nan",   {31'd0, out_nan},   32'd0);
      check("t3b_ian_scale", {24'd0, ian_out_scale}, 32'hFF);
      check("t3b_ian_inf",   {31'd0, ian_out_inf},   32'd1);
      @(posedge clk);
      #1;

      // 4: stalled output holds and blocks input (exp 250 beat must not enter)
      out_ready = 1'b0;
      send_seven(32'h3F800000, "t4_pre_valid");
      beat({4{32'h3F800000}});
      check("t4_valid", {31'd0, out_valid}, 32'd1);
      check("t4_scale", {24'd0, out_scale}, 32'h7C);
      in_valid = 1'b1;
      in_data  = {4{32'h7D000000}};
      for (int c = 0; c < 3; c++) begin
         check("t4_ready_low", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
         check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
         check("t4_hold_scale", {24'd0, out_scale}, 32'h7C);
      end
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_release", {31'd0, out_valid}, 32'd0);
      send_seven(32'h46000000, "t4b_pre_valid");
      beat({4{32'h46000000}});
      check("t4b_scale", {24'd0, out_scale}, 32'h89);

      // 5: flush after three exp-200 beats; beat in flush cycle is dropped
      for (int b = 0; b < 3; b++) beat({4{32'h64000000}});
      flush = 1'b1;
      beat({4{32'h7D000000}});
      flush = 1'b0;
      send_seven(32'h41000000, "t5_pre_valid");
      beat({4{32'h41000000}});
      check("t5_valid", {31'd0, out_valid}, 32'd1);
      check("t5_scale", {24'd0, out_scale}, 32'h7F);
      @(posedge clk);
      #1;

      // 6: async reset while a scale is held, then mid-block
      out_ready = 1'b0;
      send_seven(32'h3F800000, "t6_pre_valid");
      beat({4{32'h3F800000}});
      check("t6_valid_before", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      check("t6_rst_scale", {24'd0, out_scale}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) beat({4{32'h64000000}});
      #2 rst_n = 1'b0;
      #1;
      check("t6_mid_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_seven(32'h41000000, "t6b_pre_valid");
      beat({4{32'h41000000}});
      check("t6b_valid", {31'd0, out_valid}, 32'd1);
      check("t6b_scale", {24'd0, out_scale}, 32'h7F);

      // 7: single-beat blocks (LANES=32), replacement on the consuming edge
      out_ready32 = 1'b0;
      in_valid32  = 1'b1;
      in_data32   = {32{32'h3F800000}};
      @(posedge clk);
      #1;
      in_valid32 = 1'b0;
      check("t7_valid", {31'd0, out_valid32}, 32'd1);
      check("t7_scale", {24'd0, out_scale32}, 32'h7C);
      @(posedge clk);
      #1;
      check("t7_ready_low", {31'd0, in_ready32}, 32'd0);
      check("t7_hold",      {24'd0, out_scale32}, 32'h7C);
      in_valid32  = 1'b1;
      in_data32   = {32{32'h46000000}};
      out_ready32 = 1'b1;
      @(posedge clk);
      #1;
      in_valid32 = 1'b0;
      check("t7_replace_valid", {31'd0, out_valid32}, 32'd1);
      check("t7_replace_scale", {24'd0, out_scale32}, 32'h89);
      in_valid32 = 1'b1;
      in_data32  = {32{32'h3F800000}};
      in_data32[32*17 +: 32] = 32'h7FC00001;
      @(posedge clk);
      #1;
      in_valid32 = 1'b0;
      check("t7_nan_scale", {24'd0, out_scale32}, 32'hFF);
      check("t7_nan_flag",  {31'd0, out_nan32},   32'd1);
      @(posedge clk);
      #1;
      check("t7_drain", {31'd0, out_valid32}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
